// File: rtl/demux_1x8_deser_pkg.sv
// Shared types and constants for the 1-to-8 serial deserialiser.
//   demux_state_t : receiver FSM states (HUNT waits for SOF, ASSEMBLE collects bits)
//   DEMUX_WIDTH   : default number of lanes / word width
package demux_pkg;

  typedef enum logic {HUNT, ASSEMBLE} demux_state_t;

  localparam int DEMUX_WIDTH = 8;

endpackage

// File: rtl/demux_1x8_deser_if.sv
// Serial link + word handshake bundle between the transmitter/consumer side and the receiver.
//   D, D_VALID, SOF : serial bit, its qualifier, start-of-frame marker (driven by master)
//   Y_READY         : consumer accepts Y (driven by master)
//   S, Y, Y_VALID   : next slot, completed word, word-pending flag (driven by slave)
//   OVR, FERR       : sticky overrun / framing-error flags (driven by slave)
interface demux_1x8_deser_if
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH
);
  localparam int unsigned SEL_W = $clog2(WIDTH);

  logic             D;
  logic             D_VALID;
  logic             SOF;
  logic             Y_READY;
  logic [SEL_W-1:0] S;
  logic [WIDTH-1:0] Y;
  logic             Y_VALID;
  logic             OVR;
  logic             FERR;

  modport master (
    output D, D_VALID, SOF, Y_READY,
    input  S, Y, Y_VALID, OVR, FERR
  );

  modport slave (
    input  D, D_VALID, SOF, Y_READY,
    output S, Y, Y_VALID, OVR, FERR
  );

endinterface

// File: rtl/demux_1x8_deser_slot_ctr.sv
// Modulo-WIDTH slot counter mirroring the transmitter's mux select.
//   clk, rst      : clock, async active-high reset
//   clr_to_one_i  : start of a fresh word (slot 0 written this edge, next slot is 1)
//   inc_i         : a bit is accepted at the current slot
//   s_o           : registered next slot index
//   wrap_c_o      : combinational, high when the accepted bit fills the last slot
module demux_slot_ctr
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_to_one_i,
  input  logic                       inc_i,
  output logic [$clog2(WIDTH)-1:0]   s_o,
  output logic                       wrap_c_o
);
  localparam int unsigned SEL_W = $clog2(WIDTH);

  logic [SEL_W-1:0] s_q;
  logic [SEL_W-1:0] s_d;

  // Power-of-2 width lets the increment wrap naturally.
  always_comb begin
    s_d = s_q;
    if (clr_to_one_i) begin
      s_d = SEL_W'(1);
    end else if (inc_i) begin
      s_d = SEL_W'(s_q + SEL_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign wrap_c_o = inc_i && !clr_to_one_i && (s_q == SEL_W'(WIDTH - 1));
  assign s_o      = s_q;

endmodule

// File: rtl/demux_1x8_deser.sv
// Serial-to-parallel receiver: steers each accepted bit into lane S of an assembly
// register and hands completed words to the consumer through a one-entry holding register.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of demux_1x8_deser_if (serial input, word handshake, sticky flags)
module demux_1x8_deser
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  demux_1x8_deser_if.slave   bus
);
  localparam int unsigned SEL_W = $clog2(WIDTH);

  demux_state_t     state_q, state_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;

  logic             clr_to_one;
  logic             inc;
  logic             wrap_c;
  logic [SEL_W-1:0] s;
  logic [WIDTH-1:0] word;

  demux_slot_ctr #(.WIDTH(WIDTH)) u_slot_ctr (
    .clk          (clk),
    .rst          (rst),
    .clr_to_one_i (clr_to_one),
    .inc_i        (inc),
    .s_o          (s),
    .wrap_c_o     (wrap_c)
  );

  // Next-state: framing, assembly, holding-register handshake and sticky flags.
  always_comb begin
    state_d    = state_q;
    asm_d      = asm_q;
    y_d        = y_q;
    y_valid_d  = y_valid_q;
    ovr_d      = ovr_q;
    ferr_d     = ferr_q;
    clr_to_one = 1'b0;
    inc        = 1'b0;
    word       = asm_q;

    // Consume first; a completion on the same edge re-asserts valid below.
    if (y_valid_q && bus.Y_READY) begin
      y_valid_d = 1'b0;
    end

    unique case (state_q)
      HUNT: begin
        if (bus.D_VALID && bus.SOF) begin
          asm_d      = '0;
          asm_d[0]   = bus.D;
          clr_to_one = 1'b1;
          state_d    = ASSEMBLE;
        end
      end
      ASSEMBLE: begin
        if (bus.D_VALID) begin
          if (bus.SOF && (s != '0)) begin
            // Resynchronise: drop the partial word and restart at slot 0.
            asm_d      = '0;
            asm_d[0]   = bus.D;
            clr_to_one = 1'b1;
            ferr_d     = 1'b1;
          end else begin
            word[s] = bus.D;
            asm_d   = word;
            inc     = 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    // wrap_c only rises when inc is set, so 'word' holds the completed value here.
    if (wrap_c) begin
      if (!y_valid_q || bus.Y_READY) begin
        y_d       = word;
        y_valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HUNT;
      asm_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      asm_q     <= asm_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign bus.S       = s;
  assign bus.Y       = y_q;
  assign bus.Y_VALID = y_valid_q;
  assign bus.OVR     = ovr_q;
  assign bus.FERR    = ferr_q;

endmodule

// File: tb/tb_demux_1x8_deser.sv
// Directed self-checking bench for demux_1x8_deser.
module tb_demux_1x8_deser;
  import demux_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  demux_1x8_deser_if #(.WIDTH(8)) bus ();

  demux_1x8_deser #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic d, input logic sof, input logic rdy);
    bus.D_VALID = v;
    bus.D       = d;
    bus.SOF     = sof;
    bus.Y_READY = rdy;
    @(posedge clk);
    #1;
  endtask

  // Send one word LSB (slot 0) first; ready only on the completing bit if requested.
  task automatic send_word(input logic [7:0] w, input logic sof_first, input logic rdy_last);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, w[i], sof_first && (i == 0), rdy_last && (i == 7));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    bus.D       = 1'b0;
    bus.D_VALID = 1'b0;
    bus.SOF     = 1'b0;
    bus.Y_READY = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_S", 32'(bus.S), 32'd0);
    chk("rst_Y", 32'(bus.Y), 32'h00);
    chk("rst_YV", 32'(bus.Y_VALID), 32'd0);
    chk("rst_OVR", 32'(bus.OVR), 32'd0);
    chk("rst_FERR", 32'(bus.FERR), 32'd0);
    rst = 1'b0;

    // No SOF: bits discarded while hunting; SOF without D_VALID also ignored.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("hunt_S", 32'(bus.S), 32'd0);
    chk("hunt_YV", 32'(bus.Y_VALID), 32'd0);
    chk("hunt_Y", 32'(bus.Y), 32'h00);

    // Single word 0x4D: slots 0..7 = 1,0,1,1,0,0,1,0.
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("sof_S", 32'(bus.S), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("w1_pre_YV", 32'(bus.Y_VALID), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("w1_Y", 32'(bus.Y), 32'h4D);
    chk("w1_YV", 32'(bus.Y_VALID), 32'd1);
    chk("w1_S", 32'(bus.S), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("w1_cons_YV", 32'(bus.Y_VALID), 32'd0);
    chk("w1_cons_Y", 32'(bus.Y), 32'h4D);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("idle_rdy_YV", 32'(bus.Y_VALID), 32'd0);

    // Overrun: 0xA5 held, 0x3C dropped.
    send_word(8'hA5, 1'b0, 1'b0);
    chk("ovr_A5_Y", 32'(bus.Y), 32'hA5);
    chk("ovr_A5_OVR", 32'(bus.OVR), 32'd0);
    send_word(8'h3C, 1'b0, 1'b0);
    chk("ovr_Y", 32'(bus.Y), 32'hA5);
    chk("ovr_YV", 32'(bus.Y_VALID), 32'd1);
    chk("ovr_OVR", 32'(bus.OVR), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_sticky", 32'(bus.OVR), 32'd1);

    // Back-to-back words, consumer ready on each completing edge.
    do_reset();
    chk("rst2_OVR", 32'(bus.OVR), 32'd0);
    send_word(8'hFF, 1'b1, 1'b1);
    chk("b2b_FF_Y", 32'(bus.Y), 32'hFF);
    chk("b2b_FF_YV", 32'(bus.Y_VALID), 32'd1);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("b2b_hold_Y", 32'(bus.Y), 32'hFF);
      chk("b2b_hold_YV", 32'(bus.Y_VALID), 32'd1);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("b2b_00_Y", 32'(bus.Y), 32'h00);
    chk("b2b_00_YV", 32'(bus.Y_VALID), 32'd1);
    chk("b2b_OVR", 32'(bus.OVR), 32'd0);

    // Mid-word SOF at slot 4.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("mid_cons_YV", 32'(bus.Y_VALID), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("mid_S4", 32'(bus.S), 32'd4);
    chk("mid_FERR0", 32'(bus.FERR), 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("mid_FERR", 32'(bus.FERR), 32'd1);
    chk("mid_S1", 32'(bus.S), 32'd1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("mid_Y", 32'(bus.Y), 32'h01);
    chk("mid_YV", 32'(bus.Y_VALID), 32'd1);
    chk("mid_S0", 32'(bus.S), 32'd0);

    // Reset mid-word at slot 5 while a word is pending.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rmid_S5", 32'(bus.S), 32'd5);
    chk("rmid_YV1", 32'(bus.Y_VALID), 32'd1);
    rst = 1'b1;
    #1;
    chk("rmid_S", 32'(bus.S), 32'd0);
    chk("rmid_Y", 32'(bus.Y), 32'h00);
    chk("rmid_YV", 32'(bus.Y_VALID), 32'd0);
    chk("rmid_FERR", 32'(bus.FERR), 32'd0);
    chk("rmid_OVR", 32'(bus.OVR), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rehunt_S", 32'(bus.S), 32'd0);
    chk("rehunt_YV", 32'(bus.Y_VALID), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
